// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative M-extension multiply/divide unit:
// funct3 op codes, FSM states and default widths.
package muldiv_unit_pkg;

    localparam int MD_XLEN_DEF  = 32;
    localparam int MD_RFIDX_DEF = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_SIGN = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_div(input md_op_e o);
        return o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic op_is_rem(input md_op_e o);
        return o inside {MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply and
// restoring divide on magnitudes, with a final sign-fix cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN        = MD_XLEN_DEF,
    parameter int RFIDX_WIDTH = MD_RFIDX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [XLEN-1:0]        srca,
    input  logic [XLEN-1:0]        srcb,
    input  logic [RFIDX_WIDTH-1:0] rd,
    input  logic                   flush,
    output logic                   busy,
    output logic                   done,
    output logic [XLEN-1:0]        result,
    output logic [RFIDX_WIDTH-1:0] rdout,
    output logic [1:0]             dbg_state
);

    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e              r_state;
    md_op_e                 r_op;
    logic [RFIDX_WIDTH-1:0] r_rd;
    logic                   r_sign;
    logic [CW-1:0]          r_cnt;
    logic [XLEN-1:0]        r_operand;
    logic [2*XLEN-1:0]      r_prod;
    logic [XLEN:0]          r_rem;
    logic [XLEN-1:0]        r_quo;
    logic                   r_busy;
    logic                   r_done;
    logic [XLEN-1:0]        r_result;
    logic [RFIDX_WIDTH-1:0] r_rdout;

    md_op_e          w_op;
    logic            w_signa;
    logic            w_signb;
    logic            w_sign;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_op    = md_op_e'(op);
    assign w_signa = srca[XLEN-1] & (w_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    assign w_signb = srcb[XLEN-1] & (w_op inside {MD_MULH, MD_DIV, MD_REM});
    assign w_abs_a = w_signa ? -srca : srca;
    assign w_abs_b = w_signb ? -srcb : srcb;
    assign w_sign  = op_is_rem(w_op) ? w_signa : (w_signa ^ w_signb);

    // Divide-by-zero and signed overflow finish straight from accept.
    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (op_is_div(w_op) && (srcb == '0)) begin
            w_special     = 1'b1;
            w_special_res = op_is_rem(w_op) ? srca : '1;
        end else if ((w_op inside {MD_DIV, MD_REM}) && (srca == MOST_NEG) && (srcb == '1)) begin
            w_special     = 1'b1;
            w_special_res = (w_op == MD_DIV) ? srca : '0;
        end
    end

    // One adder serves both loops; bit XLEN+1 is the divide borrow.
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_sum;

    always_comb begin
        w_shift = {r_rem, r_quo[XLEN-1]};
        if (op_is_div(r_op)) begin
            w_sum = w_shift - {2'b00, r_operand};
        end else begin
            w_sum = {2'b00, r_prod[2*XLEN-1:XLEN]} + {2'b00, r_operand};
        end
    end

    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_val;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_final;

    assign w_prod_fix = r_sign ? -r_prod : r_prod;
    assign w_div_val  = op_is_rem(r_op) ? r_rem[XLEN-1:0] : r_quo;
    assign w_div_fix  = r_sign ? -w_div_val : w_div_val;
    assign w_final    = op_is_div(r_op) ? w_div_fix :
                        (r_op == MD_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

    // Handshake: start is taken only in IDLE/DONE with flush low; busy blocks
    // further accepts; done pulses one cycle and result/rdout hold until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= MD_IDLE;
            r_op      <= MD_MUL;
            r_rd      <= '0;
            r_sign    <= 1'b0;
            r_cnt     <= '0;
            r_operand <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rdout   <= '0;
        end else if (flush) begin
            r_state <= MD_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE, MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_busy  <= 1'b0;
                    if (start) begin
                        r_op   <= w_op;
                        r_rd   <= rd;
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_rdout  <= rd;
                            r_done   <= 1'b1;
                            r_state  <= MD_DONE;
                        end else begin
                            r_state   <= MD_RUN;
                            r_busy    <= 1'b1;
                            r_cnt     <= CW'(XLEN - 1);
                            r_operand <= op_is_div(w_op) ? w_abs_b : w_abs_a;
                            r_prod    <= {{XLEN{1'b0}}, w_abs_b};
                            r_rem     <= '0;
                            r_quo     <= w_abs_a;
                        end
                    end
                end
                MD_RUN: begin
                    if (op_is_div(r_op)) begin
                        if (!w_sum[XLEN+1]) begin
                            r_rem <= w_sum[XLEN:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[XLEN:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_prod <= r_prod[0] ? {w_sum[XLEN:0], r_prod[XLEN-1:1]}
                                            : {1'b0, r_prod[2*XLEN-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= MD_SIGN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                MD_SIGN: begin
                    r_result <= w_final;
                    r_rdout  <= r_rd;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= MD_DONE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign rdout     = r_rdout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32: arithmetic vectors, timing,
// special cases, back-to-back issue, start/flush hazards and async reset.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [RW-1:0]   rd;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rdout;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .rd        (rd),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rdout     (rdout),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issues one op in the next cycle and follows it until done (bounded).
    // With chain=1 it returns in the done cycle so the caller can issue back-to-back.
    task automatic run_op(input string tag, input md_op_e o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RW-1:0] r,
                          input logic [XLEN-1:0] exp_res, input bit special, input bit chain);
        int done_at;
        int busy_err;
        logic exp_busy;
        @(negedge clk);
        op = o; srca = a; srcb = b; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_at  = -1;
        busy_err = 0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            exp_busy = !special && (c <= XLEN + 1);
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) done_at = c;
        end
        check({tag, " done_cycle"}, done_at, special ? 1 : XLEN + 2);
        check({tag, " busy_profile_errors"}, busy_err, 0);
        check({tag, " result"}, result, exp_res);
        check({tag, " rdout"}, rdout, r);
        if (!chain) begin
            @(posedge clk); #1;
            check({tag, " done_one_cycle"}, done, 1'b0);
            check({tag, " idle_after"}, dbg_state, MD_IDLE);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int done_at;
        int n_act;

        reset = 1'b0; start = 1'b0; flush = 1'b0;
        op = '0; srca = '0; srcb = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 0);
        check("reset rdout", rdout, 0);
        check("reset state", dbg_state, MD_IDLE);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7_m3",      MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 1'b0, 1'b0);
        run_op("mulh_min_min",  MD_MULH,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 1'b0, 1'b0);
        run_op("mulhu_ones",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("mulhsu_ones",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_m7_2",      MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("rem_m7_2",      MD_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("divu_100_7",    MD_DIVU,   32'd100,      32'd7,        5'd10, 32'd14,       1'b0, 1'b1);
        run_op("remu_100_7_b2b",MD_REMU,   32'd100,      32'd7,        5'd11, 32'd2,        1'b0, 1'b0);
        run_op("div_5_0",       MD_DIV,    32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 1'b1, 1'b1);
        run_op("rem_5_0_b2b",   MD_REM,    32'd5,        32'd0,        5'd13, 32'd5,        1'b1, 1'b0);
        run_op("div_ovf",       MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1'b1, 1'b0);
        run_op("rem_ovf",       MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1'b1, 1'b0);

        // start held high through a whole op: one accept only
        @(negedge clk);
        op = MD_MUL; srca = 32'd2; srcb = 32'd5; rd = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        n_done = 0; done_at = -1;
        for (int c = 1; c <= 36; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == 5) begin
                rd = 5'd4; srca = 32'd100;
            end
            if (c == XLEN + 1) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
        end
        check("held_start done_count", n_done, 1);
        check("held_start done_cycle", done_at, XLEN + 2);
        check("held_start result", result, 32'd10);
        check("held_start rdout", rdout, 5'd9);

        // flush in cycle 10 of a divide
        @(negedge clk);
        op = MD_DIVU; srca = 32'd100; srcb = 32'd7; rd = 5'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush busy_c10", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy_c11", busy, 1'b0);
        check("flush state_c11", dbg_state, MD_IDLE);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check("flush no_done", n_done, 0);
        check("flush result_kept", result, 32'd10);
        check("flush rdout_kept", rdout, 5'd9);

        // flush and start together: request dropped
        @(negedge clk);
        op = MD_MUL; srca = 32'd3; srcb = 32'd3; rd = 5'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start state", dbg_state, MD_IDLE);
        n_act = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy === 1'b1 || done === 1'b1) n_act++;
            @(posedge clk); #1;
        end
        check("flush_start no_activity", n_act, 0);
        check("flush_start result_kept", result, 32'd10);

        // asynchronous reset in cycle 20 of a divide
        @(negedge clk);
        op = MD_DIV; srca = 32'd1000; srcb = 32'd3; rd = 5'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("rst_mid busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid busy", busy, 1'b0);
        check("rst_mid done", done, 1'b0);
        check("rst_mid result", result, 0);
        check("rst_mid rdout", rdout, 0);
        check("rst_mid state", dbg_state, MD_IDLE);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_op("mul_3_4_after_rst", MD_MUL, 32'd3, 32'd4, 5'd2, 32'd12, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
